// File: rtl/axo_pkg.sv
// Shared types and constants for the Axolotl32 fetch stage.
package axo_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRY_W = 2 * XLEN + 1;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_KILL  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/axo_fetch_fifo.sv
// Two-entry synchronous FIFO holding fetched {inst, pc, fault} entries.
module axo_fetch_fifo
  import axo_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_data_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic [1:0]         count_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [ENTRY_W-1:0] mem_q [2];
  logic [ENTRY_W-1:0] mem_d [2];
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A push into a full FIFO is allowed only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/axo32_fetch.sv
// Axolotl32 instruction fetch: owns the PC, fetches over req/ack, buffers into a 2-entry FIFO.
// Optional misaligned-redirect fault entries are enabled by AXO_FETCH_MISALIGN_TRAP_EN.
module axo32_fetch
  import axo_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        kill_q, kill_d;
  logic               pend_q, pend_d;
  logic               run_q;
  logic               push, pop, flush;
  fetch_entry_t       push_entry;
  fetch_entry_t       head;
  logic [ENTRY_W-1:0] fifo_head;
  logic [1:0]         fifo_count;
  logic               fifo_full, fifo_empty;
  logic [31:0]        rpc;
  logic               mis;

`ifdef AXO_FETCH_MISALIGN_TRAP_EN
  assign rpc        = redirect_pc;
  assign mis        = |redirect_pc[1:0];
  assign inst_fault = head.fault;
`else
  logic unused_redirect_lsbs;
  logic unused_head_fault;
  assign rpc                  = {redirect_pc[31:2], 2'b00};
  assign mis                  = 1'b0;
  assign inst_fault           = 1'b0;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign unused_head_fault    = head.fault;
`endif

  // Request is a function of registers only, so it cannot change until the ack arrives.
  assign imem_req   = run_q && (((state_q == ST_FETCH) && (fifo_count < 2'd2)) ||
                                (state_q == ST_KILL));
  assign imem_addr  = (state_q == ST_KILL) ? kill_q : pc_q;
  assign head       = fetch_entry_t'(fifo_head);
  assign inst_valid = !fifo_empty;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    pend_d     = pend_q;
    push       = 1'b0;
    flush      = 1'b0;
    pop        = inst_valid && inst_ready;
    push_entry = '{inst: imem_rdata, pc: pc_q, fault: 1'b0};
    if (redirect) begin
      flush  = 1'b1;
      pop    = 1'b0;
      pc_d   = rpc;
      pend_d = mis;
      case (state_q)
        ST_FETCH: begin
          if (imem_req && !imem_ack) begin
            kill_d  = pc_q;
            state_d = ST_KILL;
          end else begin
            state_d = mis ? ST_HALT : ST_FETCH;
          end
        end
        // An ack in this cycle completes the killed request, so no further kill is needed.
        ST_KILL: if (imem_ack) state_d = mis ? ST_HALT : ST_FETCH;
        default: state_d = mis ? ST_HALT : ST_FETCH;
      endcase
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_req && imem_ack) begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end
        ST_KILL: if (imem_ack) state_d = pend_q ? ST_HALT : ST_FETCH;
        default: begin
          if (pend_q && !fifo_full) begin
            push       = 1'b1;
            push_entry = '{inst: 32'h0000_0000, pc: pc_q, fault: 1'b1};
            pend_d     = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_VECTOR;
      kill_q  <= RESET_VECTOR;
      pend_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      pend_q  <= pend_d;
      run_q   <= 1'b1;
    end
  end

  axo_fetch_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_axo32_fetch.sv
// Self-checking bench for axo32_fetch with a configurable-latency instruction memory model.
module tb_axo32_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        redirect;
  logic [31:0] redirect_pc;

  int checks = 0;
  int fails  = 0;
  int mem_delay = 0;
  logic mem_pat = 1'b0;
  int wait_cnt = 0;

  always #5 clk = ~clk;

  axo32_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_fault  (inst_fault),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  // Memory: acks after mem_delay waiting cycles; data is 0x13 or an address-tagged word.
  assign imem_ack   = imem_req && (wait_cnt >= mem_delay);
  assign imem_rdata = mem_pat ? (32'hC0DE_0000 ^ imem_addr) : 32'h0000_0013;

  always @(posedge clk) begin
    if (!rst || !imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  typedef struct {
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0,  32'h0};
    vt[1]  = '{1'b0, 1'b1, 32'd4,  1'b1, 32'd0,  32'h13};
    vt[2]  = '{1'b0, 1'b0, 32'd8,  1'b1, 32'd0,  32'h13};
    vt[3]  = '{1'b1, 1'b0, 32'd8,  1'b1, 32'd0,  32'h13};
    vt[4]  = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd4,  32'h13};
    vt[5]  = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd8,  32'h13};
    vt[6]  = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd12, 32'h13};
    vt[7]  = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd16, 32'h13};
    vt[8]  = '{1'b0, 1'b1, 32'd24, 1'b1, 32'd20, 32'h13};
    vt[9]  = '{1'b0, 1'b0, 32'd28, 1'b1, 32'd20, 32'h13};
    vt[10] = '{1'b1, 1'b0, 32'd28, 1'b1, 32'd20, 32'h13};
    vt[11] = '{1'b1, 1'b1, 32'd28, 1'b1, 32'd24, 32'h13};

    // Reset state
    mem_pat = 1'b0; mem_delay = 0;
    do_reset();
    chk("rst req",   32'(imem_req),   32'd0);
    chk("rst addr",  imem_addr,       32'h0);
    chk("rst valid", 32'(inst_valid), 32'd0);
    chk("rst inst",  inst,            32'h0);
    chk("rst pc",    inst_pc,         32'h0);
    chk("rst fault", 32'(inst_fault), 32'd0);

    // Streaming and backpressure from reset release
    rst = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("v%0d req", i),   32'(imem_req),   32'(vt[i].exp_req));
      chk($sformatf("v%0d addr", i),  imem_addr,       vt[i].exp_addr);
      chk($sformatf("v%0d valid", i), 32'(inst_valid), 32'(vt[i].exp_valid));
      chk($sformatf("v%0d pc", i),    inst_pc,         vt[i].exp_pc);
      chk($sformatf("v%0d inst", i),  inst,            vt[i].exp_inst);
      inst_ready = vt[i].rdy;
      step();
    end

    // Redirect while a slow request is outstanding
    mem_pat = 1'b1; mem_delay = 3;
    do_reset();
    rst = 1'b1; inst_ready = 1'b1;
    step();
    chk("kill pre req", 32'(imem_req), 32'd1);
    chk("kill pre ack", 32'(imem_ack), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("kill%0d req", k),   32'(imem_req),   32'd1);
      chk($sformatf("kill%0d addr", k),  imem_addr,       32'h0);
      chk($sformatf("kill%0d valid", k), 32'(inst_valid), 32'd0);
      step();
    end
    chk("kill next addr",  imem_addr,       32'h100);
    chk("kill next valid", 32'(inst_valid), 32'd0);
    begin
      int n = 0;
      while (!inst_valid && n < 12) begin
        step();
        n++;
      end
    end
    chk("kill valid", 32'(inst_valid), 32'd1);
    chk("kill pc",    inst_pc,         32'h100);
    chk("kill inst",  inst,            32'hC0DE_0100);

    // Redirect coinciding with ack and pop
    mem_delay = 0;
    do_reset();
    rst = 1'b1; inst_ready = 1'b1;
    step();
    step();
    chk("rdack valid", 32'(inst_valid), 32'd1);
    chk("rdack pc",    inst_pc,         32'h0);
    chk("rdack ack",   32'(imem_ack),   32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    chk("rdack flush valid", 32'(inst_valid), 32'd0);
    chk("rdack new addr",    imem_addr,       32'h200);
    chk("rdack new req",     32'(imem_req),   32'd1);
    step();
    chk("rdack head valid", 32'(inst_valid), 32'd1);
    chk("rdack head pc",    inst_pc,         32'h200);
    chk("rdack head inst",  inst,            32'hC0DE_0200);

    // Misaligned redirect
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    redirect = 1'b0;
`ifdef AXO_FETCH_MISALIGN_TRAP_EN
    chk("mis flush valid", 32'(inst_valid), 32'd0);
    chk("mis flush req",   32'(imem_req),   32'd0);
    step();
    chk("mis valid", 32'(inst_valid), 32'd1);
    chk("mis fault", 32'(inst_fault), 32'd1);
    chk("mis pc",    inst_pc,         32'h102);
    chk("mis inst",  inst,            32'h0);
    chk("mis req",   32'(imem_req),   32'd0);
    step();
    chk("halt valid", 32'(inst_valid), 32'd0);
    chk("halt req0",  32'(imem_req),   32'd0);
    step();
    chk("halt req1",  32'(imem_req),   32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0104;
    step();
    redirect = 1'b0;
    chk("resume req",  32'(imem_req), 32'd1);
    chk("resume addr", imem_addr,     32'h104);
    step();
    chk("resume pc",    inst_pc,         32'h104);
    chk("resume fault", 32'(inst_fault), 32'd0);
`else
    chk("align addr",  imem_addr,       32'h100);
    chk("align valid", 32'(inst_valid), 32'd0);
    step();
    chk("align pc",    inst_pc,         32'h100);
    chk("align fault", 32'(inst_fault), 32'd0);
    chk("align inst",  inst,            32'hC0DE_0100);
`endif

    // PC wrap and mid-stream reset
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    chk("wrap addr",  imem_addr,       32'hFFFF_FFF8);
    chk("wrap valid", 32'(inst_valid), 32'd0);
    step();
    chk("wrap pc0", inst_pc, 32'hFFFF_FFF8);
    step();
    chk("wrap pc1", inst_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap pc2",   inst_pc, 32'h0000_0000);
    chk("wrap inst2", inst,    32'hC0DE_0000);
    rst = 1'b0;
    step();
    chk("mrst valid", 32'(inst_valid), 32'd0);
    chk("mrst req",   32'(imem_req),   32'd0);
    chk("mrst addr",  imem_addr,       32'h0);
    rst = 1'b1;
    step();
    chk("mrst restart req",  32'(imem_req), 32'd1);
    chk("mrst restart addr", imem_addr,     32'h0);
    step();
    chk("mrst restart pc",    inst_pc,         32'h0);
    chk("mrst restart valid", 32'(inst_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
